// File: rtl/bcd_to_binary_iterative.sv
// -----------------------------------------------------------------------------
// bcd_to_binary_iterative
//
// Multi-cycle packed-BCD to binary converter using reverse double-dabble.
// Each CONVERT cycle performs one step. The step shifts {bcd_work, binary_work}
// right by one bit. It then subtracts 3 from every BCD digit that is now >= 8.
// After WIDTH_BINARY steps:
//   - binary_work holds the value modulo 2^WIDTH_BINARY;
//   - any residue left in bcd_work means the value did not fit.
//
// Parameters
//   WIDTH_BCD     packed BCD input width (multiple of 4, digit 0 in [3:0])
//   WIDTH_BINARY  binary output width, also the number of conversion steps
//
// Ports
//   clock            rising-edge clock
//   reset            synchronous, active-high reset
//   input_bcd        BCD operand, captured on input handshake
//   input_valid      operand present
//   input_ready      high only while idle
//   output_binary    converted value modulo 2^WIDTH_BINARY
//   output_overflow  decimal value >= 2^WIDTH_BINARY
//   output_invalid   at least one input digit was > 9
//   output_valid     result present
//   output_ready     downstream accepts the result
// -----------------------------------------------------------------------------
module bcd_to_binary_iterative #(
  parameter int WIDTH_BCD    = 12,
  parameter int WIDTH_BINARY = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [WIDTH_BCD-1:0]    input_bcd,
  input  logic                    input_valid,
  output logic                    input_ready,
  output logic [WIDTH_BINARY-1:0] output_binary,
  output logic                    output_overflow,
  output logic                    output_invalid,
  output logic                    output_valid,
  input  logic                    output_ready
);

  localparam int NDIG = WIDTH_BCD / 4;
  localparam int CW   = $clog2(WIDTH_BINARY + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH_BINARY - 1);

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_DONE} state_t;

  // Per-digit correction after the right shift: a digit >= 8 received a
  // borrowed '1' worth 8 that really represents 5 in decimal, so remove 3.
  function automatic logic [WIDTH_BCD-1:0] correct_digits(input logic [WIDTH_BCD-1:0] v);
    logic [WIDTH_BCD-1:0] r;
    logic [3:0]           d;
    r = '0;
    for (int i = 0; i < NDIG; i++) begin
      d = v[i*4 +: 4];
      if (d >= 4'd8) d = d - 4'd3;
      r[i*4 +: 4] = d;
    end
    return r;
  endfunction

  function automatic logic any_bad_digit(input logic [WIDTH_BCD-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (v[i*4 +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  state_t                  state_q, state_d;
  logic [WIDTH_BCD-1:0]    bcd_work_q, bcd_work_d;
  logic [WIDTH_BINARY-1:0] binary_work_q, binary_work_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    invalid_q, invalid_d;
  logic [WIDTH_BINARY-1:0] out_binary_q, out_binary_d;
  logic                    out_overflow_q, out_overflow_d;
  logic                    out_invalid_q, out_invalid_d;
  logic                    out_valid_q, out_valid_d;

  logic [WIDTH_BCD+WIDTH_BINARY-1:0] shifted;
  logic [WIDTH_BCD-1:0]              step_bcd;
  logic [WIDTH_BINARY-1:0]           step_binary;

  always_comb begin
    shifted     = {bcd_work_q, binary_work_q} >> 1;
    step_bcd    = correct_digits(shifted[WIDTH_BCD+WIDTH_BINARY-1:WIDTH_BINARY]);
    step_binary = shifted[WIDTH_BINARY-1:0];

    state_d        = state_q;
    bcd_work_d     = bcd_work_q;
    binary_work_d  = binary_work_q;
    count_d        = count_q;
    invalid_d      = invalid_q;
    out_binary_d   = out_binary_q;
    out_overflow_d = out_overflow_q;
    out_invalid_d  = out_invalid_q;
    out_valid_d    = out_valid_q;

    case (state_q)
      S_IDLE: begin
        if (input_valid) begin
          bcd_work_d    = input_bcd;
          binary_work_d = '0;
          count_d       = '0;
          invalid_d     = any_bad_digit(input_bcd);
          state_d       = S_CONVERT;
        end
      end
      S_CONVERT: begin
        bcd_work_d    = step_bcd;
        binary_work_d = step_binary;
        count_d       = count_q + CW'(1);
        if (count_q == LAST_STEP) begin
          // Results come from this step's values, not the stale work registers.
          out_binary_d   = step_binary;
          out_overflow_d = |step_bcd;
          out_invalid_d  = invalid_q;
          out_valid_d    = 1'b1;
          state_d        = S_DONE;
        end
      end
      S_DONE: begin
        if (output_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      bcd_work_q     <= '0;
      binary_work_q  <= '0;
      count_q        <= '0;
      invalid_q      <= 1'b0;
      out_binary_q   <= '0;
      out_overflow_q <= 1'b0;
      out_invalid_q  <= 1'b0;
      out_valid_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      bcd_work_q     <= bcd_work_d;
      binary_work_q  <= binary_work_d;
      count_q        <= count_d;
      invalid_q      <= invalid_d;
      out_binary_q   <= out_binary_d;
      out_overflow_q <= out_overflow_d;
      out_invalid_q  <= out_invalid_d;
      out_valid_q    <= out_valid_d;
    end
  end

  assign input_ready     = (state_q == S_IDLE);
  assign output_binary   = out_binary_q;
  assign output_overflow = out_overflow_q;
  assign output_invalid  = out_invalid_q;
  assign output_valid    = out_valid_q;

endmodule

// File: doc/bcd_to_binary_iterative.md
# bcd_to_binary_iterative

Multi-cycle BCD-to-binary converter using reverse double-dabble: one shift-right plus per-digit correction per clock, with valid/ready handshakes on both sides. It is the sequential, area-lean counterpart to the combinational `binary_to_bcd`. It sits between decimal front-ends (keypads, display buffers, text parsers) and binary datapaths where throughput needs are low and a wide combinational tree is too costly.

## Interface
- `WIDTH_BCD`, 12: packed BCD input width; must be a multiple of 4; digit 0 is `[3:0]`.
- `WIDTH_BINARY`, 8: binary output width; it is also the iteration count N.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  reset; synchronous, active-high.
- `input_bcd`  in  WIDTH_BCD  BCD operand; sampled on input handshake.
- `input_valid`  in  1  operand present.
- `input_ready`  out  1  block can accept an operand (high only in IDLE).
- `output_binary`  out  WIDTH_BINARY  converted value, modulo 2^WIDTH_BINARY.
- `output_overflow`  out  1  decimal value ≥ 2^WIDTH_BINARY.
- `output_invalid`  out  1  at least one input digit > 9.
- `output_valid`  out  1  result present.
- `output_ready`  in  1  downstream accepts result.

## Operation
- Internal state:
  - work register `bcd_work` (WIDTH_BCD);
  - shift register `binary_work` (WIDTH_BINARY);
  - step counter, width `$clog2(WIDTH_BINARY+1)`;
  - sticky `invalid` flag.
- FSM states: IDLE, CONVERT, DONE.
- IDLE:
  - `input_ready`=1.
  - On `input_valid & input_ready`, load `bcd_work`←`input_bcd`, `binary_work`←0, counter←0.
  - In the same edge, set `invalid` = OR over digits of (digit > 9).
  - Go to CONVERT.
- CONVERT, one step per cycle:
  - Shift the concatenation {bcd_work, binary_work} right by 1.
  - The LSB of `bcd_work` enters the MSB of `binary_work`.
  - Then, for every digit of the shifted `bcd_work` with value ≥ 8, subtract 3 (4-bit arithmetic, no inter-digit carry).
  - Counter increments.
  - After step N (counter reaches N−1 at the edge), go to DONE.
  - Load `output_binary`←final `binary_work`, `output_overflow`←(final `bcd_work` ≠ 0), `output_invalid`←`invalid`.
- DONE:
  - `output_valid`=1; outputs held stable until `output_valid & output_ready`, then go to IDLE.
  - `input_valid` is ignored outside IDLE.
- Overflow: `output_binary` = decimal value mod 2^WIDTH_BINARY (low bits are still exact).
- Invalid digits: the algorithm runs unchanged; `output_binary` and `output_overflow` are unspecified when `output_invalid`=1.
- Zero operand: produces 0, with overflow=0 and invalid=0.

## Timing
- Reset values:
  - state IDLE;
  - `input_ready`=1 (combinational from state, so 1 during and after reset);
  - `output_valid`=0, `output_binary`=0, `output_overflow`=0, `output_invalid`=0;
  - internal registers 0.
- Latency:
  - input handshake at edge E0;
  - `output_valid` rises after edge E_N (N = WIDTH_BINARY cycles later).
- Throughput:
  - the minimum handshake-to-handshake interval is N+2 edges (accept, N steps, output handshake, return to IDLE);
  - no overlap of an accept with a pending result.
- `input_ready` and `output_valid` are registered-state decodes; neither depends combinationally on `input_valid`/`output_ready`.
- Backpressure: `output_ready` low holds DONE indefinitely; all outputs are constant.
- Reset mid-operation (any state) returns to IDLE at the next edge and discards any in-flight or pending result; `output_valid`=0 after that edge.
- Reset and handshake in the same cycle: reset wins.

## Test plan
Defaults unless stated (WIDTH_BCD=12, WIDTH_BINARY=8).
- In-range value: `input_bcd`=0x255 → `output_binary`=0xFF, overflow=0, invalid=0; `output_valid` high exactly 8 cycles after the accept edge.
- Overflow:
  - 0x256 → binary 0x00, overflow=1;
  - 0x999 → binary 0xE7 (999 mod 256), overflow=1.
- Invalid digit: 0x0A0 → `output_invalid`=1; 0x090 → 0x5A, invalid=0.
- Backpressure and idle gating:
  - hold `output_ready`=0 for 5 cycles after `output_valid` → outputs unchanged;
  - `input_ready`=0 throughout CONVERT/DONE;
  - `input_valid` pulsed during CONVERT is not captured.
- Reset mid-conversion: assert `reset` at step 3 of converting 0x123 → next cycle `output_valid`=0, `input_ready`=1; a fresh 0x042 then yields 0x2A.
- Exhaustive sweep: all 0..999 encoded as BCD with random `output_ready` stalls.
  - Every result must match a reference decimal→binary model: value mod 256, with overflow iff value > 255.
  - Every result must round-trip through `binary_to_bcd` for values ≤ 255.
